cla_subtractor_pipe: RTL and testbench

//   Pipelined N-bit subtractor: D = A - B - Bin, carried out as A + ~B + ~Bin on 4-bit

---
 rtl/cla_subtractor_pipe_pkg.sv | 32 +++
 rtl/cla_subtractor_pipe_if.sv | 42 ++++
 rtl/cla_group4.sv | 34 +++
 rtl/cla_subtractor_pipe.sv | 105 ++++++++++
 tb/tb_cla_subtractor_pipe.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/cla_subtractor_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cla_pkg
// Description : Shared constants and 4-bit carry-look-ahead helper.
// Revision    : 1.0
// ============================================================================
package cla_pkg;

    localparam int GROUP_W = 4;

    // Returns {cout, sum} of a + b + cin using look-ahead carries.
    function automatic logic [GROUP_W:0] cla4(
        input logic [GROUP_W-1:0] a,
        input logic [GROUP_W-1:0] b,
        input logic               cin
    );
        logic [GROUP_W-1:0] g;
        logic [GROUP_W-1:0] p;
        logic [GROUP_W:0]   c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[GROUP_W-1:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_subtractor_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : cla_subtractor_pipe_if
// Description : Input/output valid-ready bus of the pipelined subtractor.
//               Optional macro OVF_FLAG_EN adds the signed overflow flag V.
// Revision    : 1.0
// ============================================================================
interface cla_subtractor_pipe_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] D;
    logic         Bout;
`ifdef OVF_FLAG_EN
    logic         V;

    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, D, Bout, V
    );
    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, D, Bout, V
    );
`else
    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, D, Bout
    );
    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, D, Bout
    );
`endif
endinterface
`default_nettype wire

// File: rtl/cla_group4.sv
`default_nettype none
// ============================================================================
// Module      : cla_group4
// Description : Combinational 4-bit carry-look-ahead adder group.
// Revision    : 1.0
// ============================================================================
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a_i,
    input  logic [GROUP_W-1:0] b_i,
    input  logic               cin_i,
    output logic [GROUP_W-1:0] sum_o,
    output logic               cout_o
);
    logic [GROUP_W-1:0] w_g;
    logic [GROUP_W-1:0] w_p;
    logic [GROUP_W:0]   w_c;

    assign w_g    = a_i & b_i;
    assign w_p    = a_i ^ b_i;
    assign w_c[0] = cin_i;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign sum_o  = w_p ^ w_c[GROUP_W-1:0];
    assign cout_o = w_c[GROUP_W];
endmodule
`default_nettype wire

// File: rtl/cla_subtractor_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cla_subtractor_pipe
// Description : Pipelined D = A - B - Bin, one 4-bit CLA group per stage.
//               Optional macro OVF_FLAG_EN adds signed overflow output V.
// Revision    : 1.0
// ============================================================================
module cla_subtractor_pipe
    import cla_pkg::*;
#(
    parameter int N = 8
)(
    input  logic                 clk,
    input  logic                 rst,
    cla_subtractor_pipe_if.slave bus
);
    localparam int STAGES = N / GROUP_W;

    logic w_adv;

    assign w_adv        = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic               valid_q;
        logic [N-1:0]       a_q;
        logic [N-1:0]       b_q;
        logic [N-1:0]       d_q;
        // Borrow rather than carry is stored so that reset leaves Bout at 0.
        logic               borrow_q;

        logic               w_valid;
        logic [N-1:0]       w_a;
        logic [N-1:0]       w_b;
        logic [N-1:0]       w_d;
        logic               w_cin;
        logic [GROUP_W-1:0] w_sum;
        logic               w_cout;
        logic [N-1:0]       d_d;

        if (k == 0) begin : g_first
            assign w_valid = bus.in_valid;
            assign w_a     = bus.A;
            assign w_b     = bus.B;
            assign w_d     = '0;
            assign w_cin   = ~bus.Bin;
        end else begin : g_next
            assign w_valid = g_stage[k-1].valid_q;
            assign w_a     = g_stage[k-1].a_q;
            assign w_b     = g_stage[k-1].b_q;
            assign w_d     = g_stage[k-1].d_q;
            assign w_cin   = ~g_stage[k-1].borrow_q;
        end

        cla_group4 u_group (
            .a_i    (w_a[k*GROUP_W +: GROUP_W]),
            .b_i    (~w_b[k*GROUP_W +: GROUP_W]),
            .cin_i  (w_cin),
            .sum_o  (w_sum),
            .cout_o (w_cout)
        );

        always_comb begin
            d_d                        = w_d;
            d_d[k*GROUP_W +: GROUP_W]  = w_sum;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q  <= 1'b0;
                a_q      <= '0;
                b_q      <= '0;
                d_q      <= '0;
                borrow_q <= 1'b0;
            end else if (w_adv) begin
                valid_q  <= w_valid;
                a_q      <= w_a;
                b_q      <= w_b;
                d_q      <= d_d;
                borrow_q <= ~w_cout;
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].valid_q;
    assign bus.D         = g_stage[STAGES-1].d_q;
    assign bus.Bout      = g_stage[STAGES-1].borrow_q;

`ifdef OVF_FLAG_EN
    logic w_sa;
    logic w_sb;
    logic w_unused_ops;

    assign w_sa         = g_stage[STAGES-1].a_q[N-1];
    assign w_sb         = g_stage[STAGES-1].b_q[N-1];
    assign bus.V        = (w_sa != w_sb) && (bus.D[N-1] != w_sa);
    assign w_unused_ops = ^{g_stage[STAGES-1].a_q[N-2:0], g_stage[STAGES-1].b_q[N-2:0]};
`else
    logic w_unused_ops;

    assign w_unused_ops = ^{g_stage[STAGES-1].a_q, g_stage[STAGES-1].b_q};
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla_subtractor_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_subtractor_pipe
// Description : Directed and randomized self-checking bench for the subtractor.
// Revision    : 1.0
// ============================================================================
module tb_cla_subtractor_pipe;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // Expected entries are {V, Bout, D}.
    logic [N+1:0] exp_q[$];
    logic [N+1:0] cur_exp;

    always #5 clk = ~clk;

    cla_subtractor_pipe_if #(.N(N)) bus ();

    cla_subtractor_pipe #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic bin);
        logic [N:0] diff;
        logic       v;
        diff = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
        v    = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
        return {v, diff};
    endfunction

    // Called at posedge+1; samples handshakes, crosses one edge, returns at posedge+1.
    task automatic tick();
        logic         acc;
        logic         pop;
        logic [N+1:0] e;
        #2;
        acc = bus.in_valid && bus.in_ready;
        pop = bus.out_valid && bus.out_ready;
        if (pop) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("D", {24'd0, bus.D}, {24'd0, e[N-1:0]});
                chk("Bout", {31'd0, bus.Bout}, {31'd0, e[N]});
`ifdef OVF_FLAG_EN
                chk("V", {31'd0, bus.V}, {31'd0, e[N+1]});
`endif
            end
        end
        @(posedge clk);
        #1;
        if (acc) exp_q.push_back(cur_exp);
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                        input logic [N+1:0] expv);
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.Bin      = bin;
        cur_exp      = expv;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        chk(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Bin       = 1'b0;
        bus.out_ready = 1'b1;
        cur_exp       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_D", {24'd0, bus.D}, 32'd0);
        chk("rst_Bout", {31'd0, bus.Bout}, 32'd0);
`ifdef OVF_FLAG_EN
        chk("rst_V", {31'd0, bus.V}, 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Single vector with explicit two-cycle latency check.
        send(8'h0F, 8'h01, 1'b0, {1'b0, 1'b0, 8'h0E});
        chk("lat_t0_out_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        chk("lat_t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("lat_t1_D", {24'd0, bus.D}, 32'h0E);
        drain("drain_v1");

        send(8'h00, 8'h01, 1'b0, {1'b0, 1'b1, 8'hFF});
        drain("drain_wrap");
        send(8'h55, 8'hAA, 1'b1, {1'b1, 1'b1, 8'hAA});
        drain("drain_55_AA");
        send(8'hFF, 8'hFF, 1'b0, {1'b0, 1'b0, 8'h00});
        drain("drain_FF_FF");
`ifdef OVF_FLAG_EN
        send(8'h80, 8'h01, 1'b0, {1'b1, 1'b0, 8'h7F});
        drain("drain_ovf_pos");
        send(8'h05, 8'h03, 1'b0, {1'b0, 1'b0, 8'h02});
        drain("drain_ovf_none");
`endif

        // Back-to-back stream: outputs valid on four consecutive cycles.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.A   = 8'h10 + 8'(i * 8'h11);
            bus.B   = 8'(i * 3);
            bus.Bin = i[0];
            cur_exp = model(bus.A, bus.B, bus.Bin);
            tick();
            chk("stream_out_valid", {31'd0, bus.out_valid}, (i >= 1) ? 32'd1 : 32'd0);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("stream_tail_valid", {31'd0, bus.out_valid}, 32'd1);
        tick();
        chk("stream_end_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("stream_all_out", exp_q.size(), 32'd0);

        // Stall three cycles with a result at the output.
        send(8'h9C, 8'h27, 1'b0, {1'b0, 1'b0, 8'h75});
        send(8'h31, 8'h42, 1'b1, {1'b0, 1'b1, 8'hEE});
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.A         = 8'h7F;
        bus.B         = 8'h80;
        bus.Bin       = 1'b0;
        cur_exp       = {1'b1, 1'b1, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_D", {24'd0, bus.D}, 32'h75);
            chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() < 3; i++) tick();
        chk("stall_accepted", exp_q.size() > 0 ? 32'd1 : 32'd0, 32'd1);
        bus.A   = 8'h20;
        bus.B   = 8'h21;
        bus.Bin = 1'b1;
        cur_exp = {1'b0, 1'b1, 8'hFE};
        tick();
        bus.in_valid = 1'b0;
        drain("stall_drain");

        // Reset with two results in flight flushes them.
        bus.out_ready = 1'b0;
        send(8'h11, 8'h01, 1'b0, {1'b0, 1'b0, 8'h10});
        send(8'h22, 8'h02, 1'b0, {1'b0, 1'b0, 8'h20});
        rst = 1'b1;
        tick();
        exp_q.delete();
        chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("flush_quiet", {31'd0, bus.out_valid}, 32'd0);
        end

        // Randomized traffic with random bubbles and back-pressure.
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.A         = 8'($urandom);
            bus.B         = 8'($urandom);
            bus.Bin       = 1'($urandom);
            cur_exp       = model(bus.A, bus.B, bus.Bin);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain("random_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
